pad_row_sequencer: RTL and testbench

- Sits directly upstream of the convolution-layer padding stage.
- Accepts RGB input-image row chunks from a valid/ready source and drives the padding stage's enable, chunk index (count), row index (cycle) and R/G/B chunk buses.
- Inserts the top and bottom zero-padding rows, so one frame is ROWS rows × CHUNKS chunks.
- Consumes exactly (ROWS-2)×CHUNKS input beats per frame.

---
 rtl/pad_row_sequencer.sv | 158 +++++++++++++++
 tb/tb_pad_row_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_row_sequencer.sv
// pad_row_sequencer
//   Feeds the convolution padding stage one padded frame at a time. A frame is
//   ROWS rows of CHUNKS chunks: an all-zero top row, ROWS-2 rows taken from the
//   input stream, and an all-zero bottom row.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       frame start pulse, only looked at in IDLE
//   in_valid    source presents a chunk on R_in/G_in/B_in
//   in_ready    sequencer takes the chunk this cycle (high only in ROW)
//   R_in/G_in/B_in   input colour chunks, DW bits each
//   en          count/cycle/R_out/G_out/B_out carry a new beat this cycle
//   count       chunk index of the current beat (0..CHUNKS-1)
//   cycle       row index of the current beat (0..ROWS-1)
//   R_out/G_out/B_out   registered colour chunks
//   busy        high from start acceptance until frame_done
//   frame_done  one-cycle pulse after the last beat of a frame
//
// Handshake: a chunk is transferred on a rising edge where in_valid and
// in_ready are both high. in_valid may sit high while in_ready is low; the
// source then keeps the same chunk on the bus until it is taken.
module pad_row_sequencer #(
    parameter int DW     = 52,
    parameter int CHUNKS = 8,
    parameter int ROWS   = 416
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] R_in,
    input  logic [DW-1:0] G_in,
    input  logic [DW-1:0] B_in,
    output logic          en,
    output logic [3:0]    count,
    output logic [8:0]    cycle,
    output logic [DW-1:0] R_out,
    output logic [DW-1:0] G_out,
    output logic [DW-1:0] B_out,
    output logic          busy,
    output logic          frame_done
);

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] LAST_CHUNK    = CW'(CHUNKS - 1);
    localparam logic [RW-1:0] LAST_DATA_ROW = RW'(ROWS - 2);
    localparam logic [8:0]    BOT_ROW       = 9'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PAD_TOP,
        ROW,
        PAD_BOT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] chunk;
    logic [RW-1:0] row;
    logic          last_chunk;
    logic          accept;

    assign last_chunk = (chunk == LAST_CHUNK);
    assign in_ready   = (state == ROW);
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            chunk      <= '0;
            row        <= '0;
            en         <= 1'b0;
            count      <= '0;
            cycle      <= '0;
            R_out      <= '0;
            G_out      <= '0;
            B_out      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // en and frame_done are single-cycle strobes; count/cycle/data
            // hold whenever no beat is produced.
            en         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PAD_TOP;
                        busy  <= 1'b1;
                        chunk <= '0;
                        row   <= '0;
                    end
                end
                PAD_TOP: begin
                    en    <= 1'b1;
                    count <= 4'(chunk);
                    cycle <= '0;
                    R_out <= '0;
                    G_out <= '0;
                    B_out <= '0;
                    if (last_chunk) begin
                        chunk <= '0;
                        row   <= RW'(1);
                        state <= ROW;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                ROW: begin
                    if (accept) begin
                        en    <= 1'b1;
                        count <= 4'(chunk);
                        cycle <= 9'(row);
                        R_out <= R_in;
                        G_out <= G_in;
                        B_out <= B_in;
                        if (last_chunk) begin
                            chunk <= '0;
                            row   <= row + 1'b1;
                            if (row == LAST_DATA_ROW) begin
                                state <= PAD_BOT;
                            end
                        end else begin
                            chunk <= chunk + 1'b1;
                        end
                    end
                end
                PAD_BOT: begin
                    en    <= 1'b1;
                    count <= 4'(chunk);
                    cycle <= BOT_ROW;
                    R_out <= '0;
                    G_out <= '0;
                    B_out <= '0;
                    if (last_chunk) begin
                        chunk <= '0;
                        state <= DONE;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_row_sequencer.sv
// Bench for pad_row_sequencer: a driver task streams frames with optional
// gaps, stray start pulses and a mid-frame reset; a negedge monitor keeps an
// expected-beat queue filled from the stimulus and compares every en beat,
// hold behaviour, in_ready, busy and frame_done.
module tb_pad_row_sequencer;

    localparam int DW          = 52;
    localparam int CHUNKS      = 8;
    localparam int ROWS        = 416;
    localparam int NBEATS      = (ROWS - 2) * CHUNKS;
    localparam int NEN         = ROWS * CHUNKS;
    localparam int ABORT_BEAT  = (200 - 1) * CHUNKS + 3;
    localparam int EW          = 9 + 4 + 3 * DW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] R_in, G_in, B_in;
    logic          en;
    logic [3:0]    count;
    logic [8:0]    cycle;
    logic [DW-1:0] R_out, G_out, B_out;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_en     = 0;
    int n_acc    = 0;

    logic [EW-1:0] exp_q[$];

    // monitor model state
    bit            m_idle     = 1'b1;
    bit            m_in_row   = 1'b0;
    bit            m_busy     = 1'b0;
    bit            m_done_due = 1'b0;
    bit            have_last  = 1'b0;
    int            m_row      = 0;
    int            m_chunk    = 0;
    logic [EW-1:0] last_e;
    logic [EW-1:0] mon_e;

    pad_row_sequencer #(.DW(DW), .CHUNKS(CHUNKS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .R_in       (R_in),
        .G_in       (G_in),
        .B_in       (B_in),
        .en         (en),
        .count      (count),
        .cycle      (cycle),
        .R_out      (R_out),
        .G_out      (G_out),
        .B_out      (B_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_idle     = 1'b1;
            m_in_row   = 1'b0;
            m_busy     = 1'b0;
            m_done_due = 1'b0;
            have_last  = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            check("frame_done", frame_done, m_done_due);
            if (m_done_due) m_idle = 1'b1;
            m_done_due = 1'b0;

            if (en) begin
                n_en++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {cycle, count, R_out, G_out, B_out}, mon_e);
                    last_e    = mon_e;
                    have_last = 1'b1;
                    if (mon_e[EW-1 -: 9] == 9'd0 && mon_e[EW-10 -: 4] == 4'(CHUNKS - 1))
                        m_in_row = 1'b1;
                    if (mon_e[EW-1 -: 9] == 9'(ROWS - 1) && mon_e[EW-10 -: 4] == 4'(CHUNKS - 1)) begin
                        m_done_due = 1'b1;
                        m_busy     = 1'b0;
                    end
                end
            end else if (have_last) begin
                check("hold", {cycle, count, R_out, G_out, B_out}, last_e);
            end

            check("in_ready", in_ready, m_in_row);

            if (start && m_idle) begin
                for (int i = 0; i < CHUNKS; i++)
                    exp_q.push_back({9'd0, 4'(i), {(3 * DW){1'b0}}});
                m_idle  = 1'b0;
                m_busy  = 1'b1;
                m_row   = 1;
                m_chunk = 0;
            end

            if (in_valid && in_ready && m_in_row) begin
                n_acc++;
                exp_q.push_back({9'(m_row), 4'(m_chunk), R_in, G_in, B_in});
                if (m_chunk == CHUNKS - 1) begin
                    m_chunk = 0;
                    if (m_row == ROWS - 2) begin
                        for (int i = 0; i < CHUNKS; i++)
                            exp_q.push_back({9'(ROWS - 1), 4'(i), {(3 * DW){1'b0}}});
                        m_in_row = 1'b0;
                    end
                    m_row++;
                end else begin
                    m_chunk++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic new_data(input int beat);
        R_in = DW'(beat);
        G_in = DW'({$urandom(), $urandom()});
        B_in = DW'({$urandom(), $urandom()});
    endtask

    task automatic run_frame(input int gap_pct, input int pre_stall, input bit start_in_done,
                             input bit start_in_row, input bit abort, input bit timing);
        int n = 0;
        int beat = 0;
        int en0, acc0;
        bit acc;
        bit done_seen = 1'b0;
        @(posedge clk); #1;
        en0   = n_en;
        acc0  = n_acc;
        start = 1'b1;
        new_data(0);
        in_valid = (pre_stall == 0 && gap_pct == 0);
        while (n < 8000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (frame_done) begin
                done_seen = 1'b1;
                break;
            end
            if (pre_stall > 0 && n == pre_stall) begin
                check("stall_en", en, 0);
                check("stall_ready", in_ready, 1);
                check("stall_cycle", cycle, 0);
                check("stall_count", count, 7);
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (acc) begin
                beat++;
                new_data(beat);
            end
            if (abort && beat == ABORT_BEAT) break;
            if (n < pre_stall) in_valid = 1'b0;
            else if (beat < NBEATS) in_valid = ($urandom_range(99) >= gap_pct);
            else in_valid = (gap_pct == 0);
            if (start_in_done && n == NEN + 1) start = 1'b1;
            if (start_in_row && acc && beat == 100) start = 1'b1;
        end

        if (abort) begin
            #1 reset = 1'b0;
            start    = 1'b0;
            in_valid = 1'b0;
            #1;
            check("abort_en", en, 0);
            check("abort_count_cycle", {count, cycle}, 0);
            check("abort_rgb", {R_out, G_out, B_out}, 0);
            check("abort_flags", {busy, frame_done, in_ready}, 0);
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            repeat (20) @(posedge clk);
            #1;
        end else begin
            if (!done_seen) check("frame_timeout", 0, 1);
            if (timing) check("done_latency", n, NEN + 2);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("en_total", n_en - en0, NEN);
            check("acc_total", n_acc - acc0, NBEATS);
            check("beats_sent", beat, NBEATS);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        R_in     = '0;
        G_in     = '0;
        B_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", en, 0);
        check("rst_count_cycle", {count, cycle}, 0);
        check("rst_rgb", {R_out, G_out, B_out}, 0);
        check("rst_flags", {busy, frame_done, in_ready}, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(0, 10, 1'b0, 1'b0, 1'b0, 1'b0);   // initial stall, then streaming
        run_frame(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);    // no stalls, start in DONE
        run_frame(30, 0, 1'b0, 1'b1, 1'b0, 1'b0);   // random gaps, start in ROW
        run_frame(30, 0, 1'b0, 1'b0, 1'b1, 1'b0);   // reset at row 200 chunk 3
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);    // clean frame after abort

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
